keysched_dec: RTL and testbench
===============================

KEYSCHED_DEC -- requirements
Module: keysched_dec

Interface
REQ-001 The block SHALL have the ports: clk  in  1  sole clock, rising edge.
REQ-002 The block SHALL have the ports: rst_n  in  1  reset, asynchronous, active-low.
REQ-003 The block SHALL have the ports: start  in  1  request a new 16-subkey decryption schedule.
REQ-004 The block SHALL have the ports: key  in  64 [64:1]  DES key; key[64] = DES bit 1, parity bits ignored.
REQ-005 The block SHALL have the ports: subkey  out  48 [48:1]  current subkey; subkey[48] = DES bit 1.
REQ-006 The block SHALL have the ports: subkey_valid  out  1  subkey holds a valid decryption subkey.
REQ-007 The block SHALL have the ports: subkey_ready  in  1  consumer accepts subkey this cycle.
REQ-008 The block SHALL have the ports: round  out  4 [4:1]  decryption round index minus 1 (0..15).
REQ-009 The block SHALL have the ports: busy  out  1  schedule in progress.
REQ-010 The block SHALL have the ports: done  out  1  one-cycle pulse after the 16th subkey is accepted.

Function
REQ-011 Registered state SHALL be c[28:1] and d[28:1], with DES bit 1 held at index 28.
REQ-012 The FSM SHALL have two states: IDLE and RUN.
REQ-013 In IDLE, start=1 at a rising edge SHALL load c,d <= PC-1(key), round <= 0, state <= RUN.
REQ-014 subkey SHALL be combinational PC-2(c,d).
REQ-015 subkey_valid and busy SHALL equal (state==RUN).
REQ-016 The first subkey (round 0) SHALL be K16 of the encryption schedule, i.e. PC-2 of the unrotated PC-1 halves.
REQ-017 A handshake SHALL be subkey_valid & subkey_ready at a rising edge.
REQ-018 Without a handshake, subkey, round, c and d SHALL hold stable.
REQ-019 On a handshake with round<15: round SHALL increment, and c and d SHALL each rotate right by s(round+1).
REQ-020 The rotate-right amount s SHALL be: s=1 for new round 1, 8 and 15; s=2 for new rounds 2..7 and 9..14.
REQ-021 Rotate right by 1 SHALL be {x[1], x[28:2]}; rotate right by 2 SHALL be {x[2], x[1], x[28:3]}.
REQ-022 On a handshake with round==15: state SHALL go to IDLE and done SHALL pulse high for exactly one cycle.
REQ-023 Subkeys SHALL therefore emerge in order K16..K1, one per handshake; minimum latency from start to first valid is 1 cycle, and 16 cycles to drain at full rate.
REQ-024 start while in RUN SHALL be ignored; the running schedule SHALL be unaffected.
REQ-025 start asserted in the same cycle that done is pulsed SHALL be accepted, because the state is IDLE in that cycle.
REQ-026 key SHALL be sampled only at the accepting edge; later key changes SHALL have no effect.

Reset
REQ-027 rst_n=0 SHALL asynchronously force state=IDLE, c=0, d=0, round=0, done=0.
REQ-028 Under reset, subkey_valid and busy SHALL be 0, and subkey SHALL be PC-2(0,0)=0.
REQ-029 Reset asserted mid-schedule SHALL abandon the schedule with no done pulse.
REQ-030 After rst_n deasserts, operation SHALL resume on the first rising edge.

Structure
REQ-031 PC-1 and PC-2 tables, the s(r) schedule, and the width constants (28, 48, 64) SHALL reside in the shared DES package for reuse by the encryption-side schedule.
REQ-032 The right-rotation of both halves SHALL be one combinational sub-module, shiftr_dec, taking (in_l, in_r, amt) and returning (out_l, out_r).
REQ-033 shiftr_dec SHALL be the inverse of the existing left-shift blocks.

Verification
REQ-034 Key 0x133457799BBCDFF1, start pulse, subkey_ready=1 -> first subkey 0xCB3D8B0E17F5 (round 0) and 16th subkey 0x1B02EFFC7072 (round 15); done pulses on the cycle after the 16th handshake.
REQ-035 The same key with subkey_ready toggled pseudo-randomly -> the 16 accepted values are identical to the full-rate run, and subkey stays stable while ready=0.
REQ-036 start re-pulsed at round 5 with a different key -> the sequence is unchanged and only the original key's subkeys are output.
REQ-037 rst_n pulsed low at round 9 -> outputs drop to 0 immediately with no done pulse; a subsequent start reproduces the full sequence from round 0.
REQ-038 start held high continuously with ready=1 -> back-to-back schedules with no gap cycle beyond the single IDLE cycle, and done pulses once per schedule.
REQ-039 For 100 random keys -> the output sequence equals the reverse of a reference-model encryption schedule.

Source files
------------

// File: rtl/keysched_dec_pkg.sv
// rtl/keysched_dec_pkg.sv - shared DES key-schedule tables, widths and permutation helpers
package keysched_dec_pkg;

  localparam int HALF_W   = 28;
  localparam int CD_W     = 56;
  localparam int SUBKEY_W = 48;
  localparam int KEY_W    = 64;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } ks_state_t;

  localparam int PC1_TBL [CD_W] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2_TBL [SUBKEY_W] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  // Right-rotate amount indexed by the new decryption round; entry 0 is never used.
  localparam logic [1:0] SHR_TBL [16] = '{
    2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

  // DES bit n of the key lives at key[65-n]; C bit 1 lands at cd[55].
  function automatic logic [CD_W-1:0] pc1(input logic [KEY_W:1] key);
    logic [CD_W-1:0] cd;
    for (int i = 0; i < CD_W; i++) begin
      cd[CD_W-1-i] = key[KEY_W+1-PC1_TBL[i]];
    end
    return cd;
  endfunction

  function automatic logic [SUBKEY_W:1] pc2(input logic [HALF_W:1] c, input logic [HALF_W:1] d);
    logic [CD_W:1]     cd;
    logic [SUBKEY_W:1] sk;
    cd = {c, d};
    for (int j = 0; j < SUBKEY_W; j++) begin
      sk[SUBKEY_W-j] = cd[CD_W+1-PC2_TBL[j]];
    end
    return sk;
  endfunction

endpackage

// File: rtl/keysched_dec_if.sv
// rtl/keysched_dec_if.sv - start/key request and subkey stream bundle for the decryption schedule
interface keysched_dec_if;
  import keysched_dec_pkg::*;

  logic                start;
  logic [KEY_W:1]      key;
  logic [SUBKEY_W:1]   subkey;
  logic                subkey_valid;
  logic                subkey_ready;
  logic [4:1]          round;
  logic                busy;
  logic                done;

  modport master (
    output start, key, subkey_ready,
    input  subkey, subkey_valid, round, busy, done
  );

  modport slave (
    input  start, key, subkey_ready,
    output subkey, subkey_valid, round, busy, done
  );

endinterface

// File: rtl/keysched_dec_shiftr_dec.sv
// rtl/keysched_dec_shiftr_dec.sv - combinational right-rotation of both C/D halves by 0, 1 or 2
module shiftr_dec
  import keysched_dec_pkg::*;
(
  input  logic [HALF_W:1] in_l,
  input  logic [HALF_W:1] in_r,
  input  logic [1:0]      amt,
  output logic [HALF_W:1] out_l,
  output logic [HALF_W:1] out_r
);

  always_comb begin
    out_l = in_l;
    out_r = in_r;
    case (amt)
      2'd1: begin
        out_l = {in_l[1], in_l[HALF_W:2]};
        out_r = {in_r[1], in_r[HALF_W:2]};
      end
      2'd2: begin
        out_l = {in_l[2:1], in_l[HALF_W:3]};
        out_r = {in_r[2:1], in_r[HALF_W:3]};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/keysched_dec.sv
// rtl/keysched_dec.sv - DES decryption key schedule emitting K16..K1 over a valid/ready handshake
module keysched_dec
  import keysched_dec_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  keysched_dec_if.slave bus
);

  ks_state_t       r_state, w_state_nxt;
  logic [HALF_W:1] r_c, r_d, w_c_nxt, w_d_nxt, w_c_rot, w_d_rot;
  logic [3:0]      r_round, w_round_nxt;
  logic            r_done, w_done_nxt;
  logic            w_handshake;
  logic [1:0]      w_amt;
  logic [CD_W-1:0] w_cd_load;

  assign w_cd_load   = pc1(bus.key);
  assign w_handshake = (r_state == RUN) && bus.subkey_ready;
  // Amount for the round being entered; the wrap at round 15 is never consumed.
  assign w_amt       = SHR_TBL[r_round + 4'd1];

  shiftr_dec u_shiftr (
    .in_l  (r_c),
    .in_r  (r_d),
    .amt   (w_amt),
    .out_l (w_c_rot),
    .out_r (w_d_rot)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_c     <= '0;
      r_d     <= '0;
      r_round <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_c     <= w_c_nxt;
      r_d     <= w_d_nxt;
      r_round <= w_round_nxt;
      r_done  <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_c_nxt     = r_c;
    w_d_nxt     = r_d;
    w_round_nxt = r_round;
    w_done_nxt  = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_state_nxt = RUN;
          w_c_nxt     = w_cd_load[CD_W-1:HALF_W];
          w_d_nxt     = w_cd_load[HALF_W-1:0];
          w_round_nxt = 4'd0;
        end
      end
      RUN: begin
        if (w_handshake) begin
          if (r_round == 4'd15) begin
            w_state_nxt = IDLE;
            w_done_nxt  = 1'b1;
          end else begin
            w_round_nxt = r_round + 4'd1;
            w_c_nxt     = w_c_rot;
            w_d_nxt     = w_d_rot;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign bus.subkey       = pc2(r_c, r_d);
  assign bus.subkey_valid = (r_state == RUN);
  assign bus.busy         = (r_state == RUN);
  assign bus.round        = r_round;
  assign bus.done         = r_done;

endmodule

// File: tb/tb_keysched_dec.sv
// tb/tb_keysched_dec.sv - randomized self-checking bench for keysched_dec against a DES schedule model
module tb_keysched_dec;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  keysched_dec_if bus ();

  keysched_dec dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  int pc1_t [56] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18, 10,2,59,51,43,35,27,
                     19,11,3,60,52,44,36, 63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
                     14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
  int pc2_t [48] = '{14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8, 16,7,27,20,13,2,
                     41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32};
  int lshift_t [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

  logic [47:0] exp_q[$];
  logic [47:0] got_q[$];

  // Encryption schedule K1..K16 in DES bit order, pushed to the front so exp_q[0] is K16.
  task automatic ref_sched(input logic [63:0] k);
    logic [1:64] kb;
    logic [1:56] cd;
    logic [1:28] c, d;
    logic [1:48] sk;
    kb = k;
    for (int i = 1; i <= 56; i++) cd[i] = kb[pc1_t[i-1]];
    c = cd[1:28];
    d = cd[29:56];
    exp_q.delete();
    for (int r = 0; r < 16; r++) begin
      repeat (lshift_t[r]) begin
        c = {c[2:28], c[1]};
        d = {d[2:28], d[1]};
      end
      cd = {c, d};
      for (int j = 1; j <= 48; j++) sk[j] = cd[pc2_t[j-1]];
      exp_q.push_front(sk);
    end
  endtask

  task automatic run_sched(input string tag, input logic [63:0] k, input int ready_pct,
                           input int restart_at, input logic [63:0] alt_key, input int reset_at);
    logic [47:0] prev_sk;
    logic [3:0]  prev_rnd;
    logic        prev_stall;
    logic        hs;
    int          acc;
    int          cyc;
    ref_sched(k);
    got_q.delete();
    @(negedge clk);
    bus.key = k;
    bus.start = 1'b1;
    bus.subkey_ready = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    bus.key = ~k;
    check_eq({tag, "_first_valid"}, bus.subkey_valid, 1);
    acc = 0;
    cyc = 0;
    prev_stall = 1'b0;
    prev_sk = '0;
    prev_rnd = '0;
    while (acc < 16 && cyc < 400) begin
      if (reset_at >= 0 && acc == reset_at) begin
        rst_n = 1'b0;
        #1;
        check_eq({tag, "_rst_valid"}, bus.subkey_valid, 0);
        check_eq({tag, "_rst_busy"}, bus.busy, 0);
        check_eq({tag, "_rst_subkey"}, bus.subkey, 0);
        check_eq({tag, "_rst_round"}, bus.round, 0);
        check_eq({tag, "_rst_done"}, bus.done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.subkey_ready = 1'b0;
        @(negedge clk);
        check_eq({tag, "_post_rst_done"}, bus.done, 0);
        check_eq({tag, "_post_rst_valid"}, bus.subkey_valid, 0);
        return;
      end
      if (restart_at >= 0 && int'(bus.round) == restart_at) begin
        bus.start = 1'b1;
        bus.key = alt_key;
      end else begin
        bus.start = 1'b0;
      end
      if (prev_stall) begin
        check_eq({tag, "_stall_subkey"}, bus.subkey, prev_sk);
        check_eq({tag, "_stall_round"}, bus.round, prev_rnd);
      end
      check_eq({tag, "_valid"}, bus.subkey_valid, 1);
      check_eq({tag, "_round"}, bus.round, acc);
      check_eq({tag, "_done_low"}, bus.done, 0);
      bus.subkey_ready = ($urandom_range(99) < ready_pct);
      hs = bus.subkey_valid && bus.subkey_ready;
      if (hs) begin
        check_eq({tag, "_subkey"}, bus.subkey, exp_q[acc]);
        got_q.push_back(bus.subkey);
        acc++;
      end
      prev_stall = !hs;
      prev_sk = bus.subkey;
      prev_rnd = bus.round;
      @(negedge clk);
      cyc++;
    end
    bus.start = 1'b0;
    bus.subkey_ready = 1'b0;
    check_eq({tag, "_accepted"}, acc, 16);
    check_eq({tag, "_done_pulse"}, bus.done, 1);
    check_eq({tag, "_end_busy"}, bus.busy, 0);
    check_eq({tag, "_end_valid"}, bus.subkey_valid, 0);
    @(negedge clk);
    check_eq({tag, "_done_clear"}, bus.done, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] k;
    int nv, nd;
    bus.start = 1'b0;
    bus.key = '0;
    bus.subkey_ready = 1'b0;
    #12;
    check_eq("reset_valid", bus.subkey_valid, 0);
    check_eq("reset_busy", bus.busy, 0);
    check_eq("reset_subkey", bus.subkey, 0);
    check_eq("reset_round", bus.round, 0);
    check_eq("reset_done", bus.done, 0);
    @(negedge clk);
    rst_n = 1'b1;

    k = 64'h133457799BBCDFF1;
    run_sched("known", k, 100, -1, '0, -1);
    check_eq("known_k16", got_q[0], 48'hCB3D8B0E17F5);
    check_eq("known_k1", got_q[15], 48'h1B02EFFC7072);

    run_sched("stall", k, 45, -1, '0, -1);
    check_eq("stall_k16", got_q[0], 48'hCB3D8B0E17F5);
    check_eq("stall_k1", got_q[15], 48'h1B02EFFC7072);

    run_sched("restart", k, 60, 5, 64'h0E329232EA6D0D73, -1);
    run_sched("reset9", k, 100, -1, '0, 9);
    run_sched("after_rst", k, 100, -1, '0, -1);
    check_eq("after_rst_k16", got_q[0], 48'hCB3D8B0E17F5);

    k = {$urandom, $urandom};
    ref_sched(k);
    @(negedge clk);
    bus.key = k;
    bus.start = 1'b1;
    bus.subkey_ready = 1'b1;
    nv = 0;
    nd = 0;
    for (int i = 1; i <= 51; i++) begin
      @(negedge clk);
      if (bus.subkey_valid) begin
        check_eq("b2b_round", bus.round, nv % 16);
        check_eq("b2b_subkey", bus.subkey, exp_q[nv % 16]);
        nv++;
      end
      if (bus.done) nd++;
      if (i % 17 == 0) check_eq("b2b_idle_gap", bus.subkey_valid, 0);
    end
    bus.start = 1'b0;
    check_eq("b2b_valid_count", nv, 48);
    check_eq("b2b_done_count", nd, 3);
    repeat (20) @(negedge clk);
    bus.subkey_ready = 1'b0;
    check_eq("b2b_drained", bus.busy, 0);

    for (int n = 0; n < 100; n++) begin
      k = {$urandom, $urandom};
      run_sched("rand", k, 75, -1, '0, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
